boot_loader: RTL and testbench

Boot sequencer for the single-cycle MIPS system. It holds the core in reset and streams a program into instruction memory through a byte-wide valid/ready port. It packs bytes big-endian into 32-bit words and writes them at consecutive word addresses. It then releases the core reset so execution starts at PC 0 with the loaded image.

---
 rtl/boot_pkg.sv | 16 +
 rtl/byte_packer.sv | 37 +++
 rtl/boot_loader.sv | 112 +++++++++++
 tb/tb_boot_loader.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - shared types and constants for the boot sequencer
package boot_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int PACKED_W       = BYTES_PER_WORD * 8;
    localparam int DEFAULT_ADDR_W = 6;

    typedef enum logic [2:0] {
        S_HOLD    = 3'd0,
        S_LOAD    = 3'd1,
        S_WRITE   = 3'd2,
        S_RELEASE = 3'd3,
        S_RUN     = 3'd4
    } boot_state_t;

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - assembles big-endian 32-bit words from a byte stream
module byte_packer
    import boot_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                fire,
    input  logic [7:0]          in_byte,
    output logic [PACKED_W-1:0] word,
    output logic                word_ready
);

    logic [1:0] idx;

    // word_ready marks the byte that completes the word, so the FSM can
    // move to its write cycle on the same edge the last byte lands.
    assign word_ready = fire && (idx == 2'd3);

    always_ff @(posedge clk) begin
        if (reset) begin
            idx  <= '0;
            word <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (fire) begin
            idx <= idx + 2'd1;
            case (idx)
                2'd0: word[31:24] <= in_byte;
                2'd1: word[23:16] <= in_byte;
                2'd2: word[15:8]  <= in_byte;
                2'd3: word[7:0]   <= in_byte;
            endcase
        end
    end

endmodule

// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - loads a program image into imem, then releases the core reset
module boot_loader
    import boot_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int WORD_W = PACKED_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   nwords,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wd,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

    boot_state_t         state;
    boot_state_t         state_next;
    logic [ADDR_W:0]     cnt;
    logic [ADDR_W-1:0]   addr;
    logic                load_start;
    logic                last_word;
    logic                fire;
    logic                word_ready;
    logic [PACKED_W-1:0] packed_word;

    assign last_word = ({1'b0, addr} + {{ADDR_W{1'b0}}, 1'b1}) == cnt;
    assign fire      = in_valid && (state == S_LOAD);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_HOLD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_start = 1'b0;
        case (state)
            S_HOLD: begin
                if (start) begin
                    if (nwords == '0) begin
                        state_next = S_RELEASE;
                    end else begin
                        state_next = S_LOAD;
                        load_start = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (word_ready) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                state_next = last_word ? S_RELEASE : S_LOAD;
            end
            S_RELEASE: begin
                state_next = S_RUN;
            end
            S_RUN: begin
                state_next = S_RUN;
            end
            default: begin
                state_next = S_HOLD;
            end
        endcase
    end

    // The address is held on the final write so a full-capacity load
    // finishes at the top address instead of wrapping back to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            addr <= '0;
        end else if (load_start) begin
            cnt  <= (nwords > CAPACITY) ? CAPACITY : nwords;
            addr <= '0;
        end else if (state == S_WRITE && !last_word) begin
            addr <= addr + ADDR_W'(1);
        end
    end

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (load_start),
        .fire       (fire),
        .in_byte    (in_byte),
        .word       (packed_word),
        .word_ready (word_ready)
    );

    assign in_ready  = (state == S_LOAD);
    assign mem_we    = (state == S_WRITE);
    assign mem_addr  = addr;
    assign mem_wd    = packed_word;
    assign cpu_reset = (state != S_RUN);
    assign busy      = (state == S_LOAD) || (state == S_WRITE) || (state == S_RELEASE);
    assign done      = (state == S_RUN);

endmodule

// File: tb/tb_boot_loader.sv
// tb/tb_boot_loader.sv - self-checking bench for boot_loader against a byte-list reference model
module tb_boot_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [6:0] nwords = '0;
    logic       in_valid = 1'b0;
    logic [7:0] in_byte = '0;
    logic       in_ready;
    logic       mem_we;
    logic [5:0] mem_addr;
    logic [31:0] mem_wd;
    logic       cpu_reset;
    logic       busy;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0]  tx[$];
    logic [5:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          proto_viol = 0;
    logic        prev_we = 1'b0;

    boot_loader #(.ADDR_W(6), .WORD_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .nwords    (nwords),
        .in_valid  (in_valid),
        .in_byte   (in_byte),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wd    (mem_wd),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wd);
            if (in_ready || prev_we) proto_viol <= proto_viol + 1;
        end
        prev_we <= mem_we;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    function automatic logic [31:0] exp_word(int i);
        return (32'(tx[4*i]) << 24) | (32'(tx[4*i+1]) << 16) | (32'(tx[4*i+2]) << 8) | 32'(tx[4*i+3]);
    endfunction

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic pulse_start(input int n);
        start = 1'b1;
        nwords = 7'(n);
        @(posedge clk); #1;
        start = 1'b0;
        nwords = 7'($urandom);
    endtask

    task automatic stream(input int bubble_pct, output int first_cyc);
        int idx = 0;
        int guard = 0;
        first_cyc = -1;
        while (idx < tx.size() && guard < 5000) begin
            in_valid = ($urandom_range(99) >= bubble_pct);
            in_byte  = in_valid ? tx[idx] : 8'($urandom);
            @(negedge clk);
            if (in_valid && in_ready) begin
                if (idx == 0) first_cyc = cyc;
                idx++;
            end
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        if (idx < tx.size()) begin
            n_tests++; n_fail++;
            $display("FAIL stream_timeout: sent %0d bytes, required %0d", idx, tx.size());
        end
    endtask

    task automatic wait_run(output int at_cyc);
        int g = 0;
        while (cpu_reset !== 1'b0 && g < 2000) begin
            @(negedge clk);
            g++;
        end
        at_cyc = (cpu_reset === 1'b0) ? cyc : -1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({cpu_reset, in_ready, done, mem_we, busy} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_ctrl: cpu_reset,in_ready,done,mem_we,busy=%b, required 10000",
                     {cpu_reset, in_ready, done, mem_we, busy});
        end
        n_tests++;
        if (mem_addr !== 6'd0 || mem_wd !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mem: addr=%0d wd=%h, required 0 00000000", mem_addr, mem_wd);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if ({cpu_reset, in_ready, done, mem_we, busy} !== 5'b10000) begin
                n_fail++;
                $display("FAIL hold_idle cycle %0d: ctrl=%b, required 10000", i,
                         {cpu_reset, in_ready, done, mem_we, busy});
            end
        end
        reset = 1'b1; start = 1'b1; nwords = 7'd3;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || cpu_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_beats_start: busy=%b in_ready=%b cpu_reset=%b, required 0 0 1",
                     busy, in_ready, cpu_reset);
        end
    endtask

    task automatic test_two_word();
        int base, pv0, t, r;
        do_reset();
        base = wr_addr_q.size();
        pv0 = proto_viol;
        tx = {8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h40};
        pulse_start(2);
        stream(0, t);
        wait_run(r);
        n_tests++;
        if (r !== t + 11) begin
            n_fail++;
            $display("FAIL two_word_latency: cpu_reset low at cycle %0d, required %0d", r, t + 11);
        end
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL two_word_done: done=%b busy=%b, required 1 0", done, busy);
        end
        n_tests++;
        if (wr_addr_q.size() - base != 2) begin
            n_fail++;
            $display("FAIL two_word_count: %0d writes, required 2", wr_addr_q.size() - base);
        end else begin
            n_tests++;
            if (wr_addr_q[base] !== 6'd0 || wr_data_q[base] !== 32'h20080005) begin
                n_fail++;
                $display("FAIL two_word_w0: addr=%0d data=%h, required 0 20080005",
                         wr_addr_q[base], wr_data_q[base]);
            end
            n_tests++;
            if (wr_addr_q[base+1] !== 6'd1 || wr_data_q[base+1] !== 32'hAC080040) begin
                n_fail++;
                $display("FAIL two_word_w1: addr=%0d data=%h, required 1 ac080040",
                         wr_addr_q[base+1], wr_data_q[base+1]);
            end
        end
        n_tests++;
        if (proto_viol !== pv0) begin
            n_fail++;
            $display("FAIL two_word_protocol: %0d violations, required 0", proto_viol - pv0);
        end
    endtask

    task automatic test_load(input string name, input int n, input int bubble_pct);
        int base, pv0, t, r, nexp;
        do_reset();
        base = wr_addr_q.size();
        pv0 = proto_viol;
        nexp = (n > 64) ? 64 : n;
        tx.delete();
        for (int i = 0; i < 4 * nexp; i++) tx.push_back(8'($urandom));
        pulse_start(n);
        stream(bubble_pct, t);
        wait_run(r);
        n_tests++;
        if (r < 0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_run: cpu_reset low at %0d done=%b, required release and done=1", name, r, done);
        end
        n_tests++;
        if (wr_addr_q.size() - base != nexp) begin
            n_fail++;
            $display("FAIL %s_count: %0d writes, required %0d", name, wr_addr_q.size() - base, nexp);
        end
        for (int i = 0; i < nexp && base + i < wr_addr_q.size(); i++) begin
            n_tests++;
            if (wr_addr_q[base+i] !== 6'(i) || wr_data_q[base+i] !== exp_word(i)) begin
                n_fail++;
                $display("FAIL %s_word%0d: addr=%0d data=%h, required %0d %h", name, i,
                         wr_addr_q[base+i], wr_data_q[base+i], i, exp_word(i));
            end
        end
        n_tests++;
        if (proto_viol !== pv0) begin
            n_fail++;
            $display("FAIL %s_protocol: %0d violations, required 0", name, proto_viol - pv0);
        end
        if (n > 64) begin
            n_tests++;
            if (mem_addr !== 6'd63) begin
                n_fail++;
                $display("FAIL %s_final_addr: addr=%0d, required 63", name, mem_addr);
            end
        end
    endtask

    task automatic test_bubbles();
        for (int k = 0; k < 4; k++) test_load("bubbles", $urandom_range(1, 8), 50);
    endtask

    task automatic test_clamp();
        test_load("clamp", 100, 10);
    endtask

    task automatic test_zero();
        int base;
        do_reset();
        base = wr_addr_q.size();
        pulse_start(0);
        n_tests++;
        if (cpu_reset !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_release: cpu_reset=%b busy=%b done=%b, required 1 1 0", cpu_reset, busy, done);
        end
        @(posedge clk); #1;
        n_tests++;
        if (cpu_reset !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_run: cpu_reset=%b done=%b busy=%b, required 0 1 0", cpu_reset, done, busy);
        end
        n_tests++;
        if (wr_addr_q.size() != base) begin
            n_fail++;
            $display("FAIL zero_writes: %0d writes, required 0", wr_addr_q.size() - base);
        end
    endtask

    task automatic test_start_in_load();
        logic [7:0] full[$];
        int base, t, r;
        do_reset();
        base = wr_addr_q.size();
        for (int i = 0; i < 8; i++) full.push_back(8'($urandom));
        pulse_start(2);
        tx = full[0:2];
        stream(0, t);
        pulse_start(5);
        tx = full[3:7];
        stream(0, t);
        wait_run(r);
        tx = full;
        n_tests++;
        if (r < 0 || wr_addr_q.size() - base != 2) begin
            n_fail++;
            $display("FAIL start_in_load_count: run=%0d writes=%0d, required run and 2", r, wr_addr_q.size() - base);
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_tests++;
                if (wr_addr_q[base+i] !== 6'(i) || wr_data_q[base+i] !== exp_word(i)) begin
                    n_fail++;
                    $display("FAIL start_in_load_word%0d: addr=%0d data=%h, required %0d %h", i,
                             wr_addr_q[base+i], wr_data_q[base+i], i, exp_word(i));
                end
            end
        end
    endtask

    task automatic test_start_in_run();
        int base;
        int bad = 0;
        base = wr_addr_q.size();
        in_valid = 1'b1;
        pulse_start(3);
        for (int i = 0; i < 8; i++) begin
            in_byte = 8'($urandom);
            @(negedge clk);
            if (done !== 1'b1 || cpu_reset !== 1'b0 || in_ready !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_tests++;
        if (bad != 0 || wr_addr_q.size() != base) begin
            n_fail++;
            $display("FAIL start_in_run: %0d bad cycles, %0d writes, required 0 0", bad, wr_addr_q.size() - base);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] full[$];
        int base, t, r;
        do_reset();
        base = wr_addr_q.size();
        for (int i = 0; i < 8; i++) full.push_back(8'($urandom));
        tx = full[0:5];
        pulse_start(2);
        stream(0, t);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_tests++;
        if (cpu_reset !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_hold: cpu_reset=%b busy=%b in_ready=%b done=%b, required 1 0 0 0",
                     cpu_reset, busy, in_ready, done);
        end
        tx = full;
        n_tests++;
        if (wr_addr_q.size() - base != 1 || wr_data_q[base] !== exp_word(0)) begin
            n_fail++;
            $display("FAIL reset_mid_partial: %0d writes, required 1 of %h", wr_addr_q.size() - base, exp_word(0));
        end
        base = wr_addr_q.size();
        tx.delete();
        for (int i = 0; i < 4; i++) tx.push_back(8'($urandom));
        pulse_start(1);
        stream(0, t);
        wait_run(r);
        n_tests++;
        if (r < 0 || wr_addr_q.size() - base != 1) begin
            n_fail++;
            $display("FAIL reset_mid_reload_count: run=%0d writes=%0d, required run and 1", r, wr_addr_q.size() - base);
        end else begin
            n_tests++;
            if (wr_addr_q[base] !== 6'd0 || wr_data_q[base] !== exp_word(0)) begin
                n_fail++;
                $display("FAIL reset_mid_reload: addr=%0d data=%h, required 0 %h",
                         wr_addr_q[base], wr_data_q[base], exp_word(0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_two_word();
        test_bubbles();
        test_clamp();
        test_zero();
        test_start_in_load();
        test_start_in_run();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
